// File: rtl/sine_cordic_pkg.sv
// -----------------------------------------------------------------------------
// sine_cordic_pkg
//   Shared constants, the arctangent table and the controller state type for
//   the sequential CORDIC sine unit (sine_cordic).
//
//   Fixed-point formats used throughout:
//     Q16.16  external angle and sine result (32 bits)
//     Q4.28   range-reduced angle in [-pi, pi]
//     Q2.30   CORDIC working format (34-bit signed datapath)
// -----------------------------------------------------------------------------
package sine_cordic_pkg;

  // Width of the internal signed CORDIC datapath.
  localparam int DW = 34;

  // CORDIC gain compensation 0.6072529350 in Q2.30; preloading xc with it
  // makes yc converge directly to sin(z) instead of sin(z)/K.
  localparam logic signed [DW-1:0] K_Q30       = 34'sd652032874;

  // 1/(2*pi) in Q0.32 and 2*pi in Q4.28, held at 64 bits for the reduction.
  localparam logic signed [63:0]   INV_2PI_Q32 = 64'sd683565276;
  localparam logic signed [63:0]   TWO_PI_Q28  = 64'sd1686629713;

  // pi and pi/2 in Q2.30. PI_Q30 does not fit 32 bits signed, hence DW.
  localparam logic signed [DW-1:0] PI_Q30      = 34'sd3373259426;
  localparam logic signed [DW-1:0] HALF_PI_Q30 = 34'sd1686629713;

  // Output saturation bounds: +/-1.0 in Q16.16.
  localparam logic signed [DW-1:0] SIN_MAX     = 34'sd65536;
  localparam logic signed [DW-1:0] SIN_MIN     = -34'sd65536;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_FOLD   = 2'd2,
    ST_ITER   = 2'd3
  } state_e;

  // atan(2^-i) in Q2.30, rounded to nearest, for i = 0..27.
  // From i = 10 onward atan(2^-i) rounds to exactly 2^(30-i).
  function automatic logic signed [DW-1:0] atan_q30(input logic [4:0] idx);
    logic signed [DW-1:0] v;
    v = '0;
    case (idx)
      5'd0:  v = 34'sd843314857;
      5'd1:  v = 34'sd497837829;
      5'd2:  v = 34'sd263043837;
      5'd3:  v = 34'sd133525159;
      5'd4:  v = 34'sd67021687;
      5'd5:  v = 34'sd33543516;
      5'd6:  v = 34'sd16775851;
      5'd7:  v = 34'sd8388437;
      5'd8:  v = 34'sd4194283;
      5'd9:  v = 34'sd2097149;
      5'd10: v = 34'sd1048576;
      5'd11: v = 34'sd524288;
      5'd12: v = 34'sd262144;
      5'd13: v = 34'sd131072;
      5'd14: v = 34'sd65536;
      5'd15: v = 34'sd32768;
      5'd16: v = 34'sd16384;
      5'd17: v = 34'sd8192;
      5'd18: v = 34'sd4096;
      5'd19: v = 34'sd2048;
      5'd20: v = 34'sd1024;
      5'd21: v = 34'sd512;
      5'd22: v = 34'sd256;
      5'd23: v = 34'sd128;
      5'd24: v = 34'sd64;
      5'd25: v = 34'sd32;
      5'd26: v = 34'sd16;
      5'd27: v = 34'sd8;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sine_cordic.sv
// -----------------------------------------------------------------------------
// sine_cordic
//   Sequential fixed-point sine: sin = sin(x), both signed Q16.16.
//   Flow per operation: IDLE -> REDUCE (1) -> FOLD (1) -> ITER (ITERATIONS)
//   -> IDLE. Result appears ITERATIONS+2 cycles after the accept edge.
//
//   Parameters
//     ITERATIONS  CORDIC micro-rotations, legal 16..28 (default 20)
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset; aborts any operation
//     in_valid   in   angle on x is valid this cycle
//     in_ready   out  unit idle; x is captured when in_valid is also high
//     x          in   signed Q16.16 angle in radians, full int32 range
//     out_valid  out  one-cycle pulse, sin carries a new result
//     sin        out  signed Q16.16 sine, held until the next result
// -----------------------------------------------------------------------------
module sine_cordic
  import sine_cordic_pkg::*;
#(
  parameter int ITERATIONS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  output logic [31:0] sin
);

  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  state_e               state_q, state_d;
  logic signed [31:0]   x_q, x_d;
  logic signed [DW-1:0] r_q, r_d;        // reduced angle, Q4.28
  logic signed [DW-1:0] xc_q, xc_d;      // CORDIC x, Q2.30
  logic signed [DW-1:0] yc_q, yc_d;      // CORDIC y, Q2.30
  logic signed [DW-1:0] z_q, z_d;        // residual angle, Q2.30
  logic [4:0]           iter_q, iter_d;
  logic signed [31:0]   sin_q, sin_d;
  logic                 out_valid_q, out_valid_d;

  // ---------------------------------------------------------------------------
  // Range reduction: q = round(x / 2pi) whole turns, r = x - q*2pi in Q4.28.
  // x*INV_2PI is Q16.48, so adding 2^47 and shifting by 48 rounds to the
  // nearest integer turn count.
  // ---------------------------------------------------------------------------
  logic signed [63:0]   x_ext;
  logic signed [63:0]   prod;
  logic signed [63:0]   q_turns;
  logic signed [DW-1:0] r_calc;

  always_comb begin
    x_ext   = 64'(x_q);
    prod    = x_ext * INV_2PI_Q32;
    q_turns = (prod + (64'sd1 <<< 47)) >>> 48;
    r_calc  = DW'((x_ext <<< 12) - q_turns * TWO_PI_Q28);
  end

  // ---------------------------------------------------------------------------
  // Quadrant fold: mirror angles beyond +/-pi/2 about +/-pi/2 so the CORDIC
  // only sees its convergent range. sin(pi - r) = sin(r) keeps the value.
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] z_raw;
  logic signed [DW-1:0] z_fold;

  always_comb begin
    z_raw = r_q <<< 2;  // Q4.28 -> Q2.30
    if (z_raw > HALF_PI_Q30) begin
      z_fold = PI_Q30 - z_raw;
    end else if (z_raw < -HALF_PI_Q30) begin
      z_fold = -PI_Q30 - z_raw;
    end else begin
      z_fold = z_raw;
    end
  end

  // ---------------------------------------------------------------------------
  // One rotation-mode micro-rotation per cycle; d = +1 when z >= 0.
  // Both cross terms use the pre-update xc/yc.
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] x_shift, y_shift, atan_i;
  logic signed [DW-1:0] xc_rot, yc_rot, z_rot;
  logic signed [DW-1:0] sin_round, sin_clamp;

  always_comb begin
    x_shift = xc_q >>> iter_q;
    y_shift = yc_q >>> iter_q;
    atan_i  = atan_q30(iter_q);
    if (!z_q[DW-1]) begin
      xc_rot = xc_q - y_shift;
      yc_rot = yc_q + x_shift;
      z_rot  = z_q - atan_i;
    end else begin
      xc_rot = xc_q + y_shift;
      yc_rot = yc_q - x_shift;
      z_rot  = z_q + atan_i;
    end

    // Q2.30 -> Q16.16 with round-half-up, then saturate to +/-1.0 since the
    // final yc may land a hair above 2^30.
    sin_round = (yc_rot + 34'sd8192) >>> 14;
    if (sin_round > SIN_MAX) begin
      sin_clamp = SIN_MAX;
    end else if (sin_round < SIN_MIN) begin
      sin_clamp = SIN_MIN;
    end else begin
      sin_clamp = sin_round;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller / next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    r_d         = r_q;
    xc_d        = xc_q;
    yc_d        = yc_q;
    z_d         = z_q;
    iter_d      = iter_q;
    sin_d       = sin_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x;
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        r_d     = r_calc;
        state_d = ST_FOLD;
      end
      ST_FOLD: begin
        xc_d    = K_Q30;
        yc_d    = '0;
        z_d     = z_fold;
        iter_d  = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        xc_d   = xc_rot;
        yc_d   = yc_rot;
        z_d    = z_rot;
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_ITER) begin
          // Result is taken from the last rotation directly, so the unit is
          // back in IDLE in the same cycle out_valid is high.
          sin_d       = 32'(sin_clamp);
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      r_q         <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      z_q         <= '0;
      iter_q      <= '0;
      sin_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      r_q         <= r_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      z_q         <= z_d;
      iter_q      <= iter_d;
      sin_q       <= sin_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign sin       = sin_q;

endmodule

// File: tb/tb_sine_cordic.sv
// -----------------------------------------------------------------------------
// tb_sine_cordic
//   Directed self-checking bench for sine_cordic. Expected values are either
//   listed constants or taken from the real-valued $sin reference.
// -----------------------------------------------------------------------------
module tb_sine_cordic;

  localparam int ITER = 20;
  localparam int LAT  = ITER + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic [31:0] sin;

  int checks = 0;
  int errors = 0;

  sine_cordic #(.ITERATIONS(ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .out_valid(out_valid),
    .sin      (sin)
  );

  always #5 clk = ~clk;

  function automatic int ref_sin(input int xv);
    real a;
    a = $sin(real'(xv) / 65536.0) * 65536.0;
    return int'(a);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Present one angle, release in_valid after the accept edge and wait for
  // the result. lat = edges from accept to out_valid, 0 on timeout.
  task automatic run_one(input int xv, output int res, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    x        = xv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    res = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        res = int'($signed(sin));
        break;
      end
    end
    $display("xact x=%0d sin=%0d lat=%0d", xv, res, lat);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (sin !== 32'd0) begin
      errors++; $display("FAIL reset_sin got=%0d want=0", $signed(sin));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_known();
    int kx[5] = '{0, 102944, -102944, 34315, 205887};
    int ke[5] = '{0, 65536, -65536, 32768, 0};
    int res, lat;
    logic [31:0] held;
    for (int k = 0; k < 5; k++) begin
      run_one(kx[k], res, lat);
      checks++;
      if (iabs(res - ke[k]) > 4) begin
        errors++; $display("FAIL known_value x=%0d got=%0d want=%0d+-4", kx[k], res, ke[k]);
      end
      checks++;
      if (lat != LAT) begin
        errors++; $display("FAIL known_latency x=%0d got=%0d want=%0d", kx[k], lat, LAT);
      end
    end
    // out_valid is a single-cycle pulse and sin holds afterwards
    held = sin;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL pulse_width got=%b want=0", out_valid);
    end
    checks++;
    if (sin !== held) begin
      errors++; $display("FAIL sin_hold got=%0d want=%0d", $signed(sin), $signed(held));
    end
  endtask

  task automatic test_sweep();
    int res, lat, xv, exp_v;
    for (int i = -720; i <= 720; i += 10) begin
      xv = (i * 205887) / 180;
      exp_v = ref_sin(xv);
      run_one(xv, res, lat);
      checks++;
      if (iabs(res - exp_v) > 4 || lat != LAT) begin
        errors++;
        $display("FAIL sweep deg=%0d x=%0d got=%0d lat=%0d want=%0d+-4 lat=%0d",
                 i, xv, res, lat, exp_v, LAT);
      end
    end
    run_one(823548, res, lat);
    checks++;
    if (iabs(res - (-2)) > 4) begin
      errors++; $display("FAIL four_pi got=%0d want=-2+-4", res);
    end
  endtask

  task automatic test_large();
    int lx[4] = '{32'h7FFF0000, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};
    int res, lat, exp_v;
    for (int k = 0; k < 4; k++) begin
      exp_v = ref_sin(lx[k]);
      run_one(lx[k], res, lat);
      checks++;
      if (iabs(res - exp_v) > 16) begin
        errors++; $display("FAIL large x=%0d got=%0d want=%0d+-16", lx[k], res, exp_v);
      end
    end
  endtask

  task automatic test_symmetry();
    int sx[5] = '{12345, 100000, 300000, 1000000, 20000000};
    int rp, rn, lat;
    for (int k = 0; k < 5; k++) begin
      run_one(sx[k], rp, lat);
      run_one(-sx[k], rn, lat);
      checks++;
      if (iabs(rp + rn) > 1) begin
        errors++; $display("FAIL symmetry x=%0d got=%0d/%0d want=sum within 1", sx[k], rp, rn);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit pending = 0;
    bit ready_leak = 0;
    int pend_x = 0;
    int pend_cyc = 0;
    int last_ov = -10;
    int results = 0;
    int exp_v;
    for (int c = 0; c < 4 * LAT + 10 && results < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x = -400000 + (c * 13001) % 800000;
      if (in_ready) begin
        if (pending) begin
          ready_leak = 1;
        end else begin
          pend_x   = int'(x);
          pend_cyc = c;
          pending  = 1;
          if (results > 0) begin
            checks++;
            if (c != last_ov + 1) begin
              errors++; $display("FAIL b2b_accept cyc=%0d want=%0d", c, last_ov + 1);
            end
          end
        end
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        results++;
        exp_v = ref_sin(pend_x);
        $display("xact b2b x=%0d sin=%0d lat=%0d", pend_x, $signed(sin), c - pend_cyc);
        checks++;
        if (!pending || (c - pend_cyc) != LAT) begin
          errors++; $display("FAIL b2b_latency got=%0d want=%0d", c - pend_cyc, LAT);
        end
        checks++;
        if (iabs(int'($signed(sin)) - exp_v) > 4) begin
          errors++; $display("FAIL b2b_value x=%0d got=%0d want=%0d+-4", pend_x, $signed(sin), exp_v);
        end
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_on_valid got=%b want=1", in_ready);
        end
        pending = 0;
        last_ov = c;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (results != 3) begin
      errors++; $display("FAIL b2b_count got=%0d want=3", results);
    end
    checks++;
    if (ready_leak) begin
      errors++; $display("FAIL b2b_busy_ready got=1 want=0");
    end
    // let any in-flight operation drain
    repeat (LAT + 2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int res, lat, seen;
    run_one(34315, res, lat);
    checks++;
    if (iabs(res - 32768) > 4) begin
      errors++; $display("FAIL pre_abort got=%0d want=32768+-4", res);
    end
    @(negedge clk);
    in_valid = 1'b1;
    x = 102944;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (sin !== 32'd0) begin
      errors++; $display("FAIL abort_sin got=%0d want=0", $signed(sin));
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_no_result got=%0d pulses want=0", seen);
    end
    run_one(102944, res, lat);
    checks++;
    if (iabs(res - 65536) > 4 || lat != LAT) begin
      errors++; $display("FAIL post_abort got=%0d lat=%0d want=65536+-4 lat=%0d", res, lat, LAT);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = '0;
    test_reset();
    test_known();
    test_sweep();
    test_large();
    test_symmetry();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
